message_hub_router: RTL and testbench

//  Hub one level above the PU arbitration units. Upstream: round-robin merges the master_fifo_out

---
 rtl/message_hub_router.sv | 155 +++++++++++++++
 tb/tb_message_hub_router.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/message_hub_router.sv
// message_hub_router: hub above the PU arbitration units.
// Upstream merges the unit out-FIFOs round-robin into one uplink word stream.
// Downstream routes uplink words by header to the unit in-FIFOs, and counts
// the words it drops because their header names no port.
// Each direction has a one-entry register buffer.

// Per-port strobe decode: a port pops when it holds the grant and pushes when
// it is the destination of the buffered downstream word.
module message_hub_router_lane #(
    parameter int PW  = 2,
    parameter int HW  = 4,
    parameter int IDX = 0
) (
    input  logic          pop_en,
    input  logic [PW-1:0] gnt_idx,
    input  logic          push_en,
    input  logic [HW-1:0] dest,
    output logic          pop,
    output logic          push
);
    assign pop  = pop_en  && (gnt_idx == PW'(IDX));
    assign push = push_en && (dest == HW'(IDX));
endmodule

module message_hub_router #(
    parameter int PORT_COUNT       = 4,
    parameter int FINAL_FIFO_WIDTH = 32,
    parameter int HEADER_WIDTH     = 4,
    parameter int DROP_CNT_WIDTH   = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [PORT_COUNT*FINAL_FIFO_WIDTH-1:0] port_out_data,
    input  logic [PORT_COUNT-1:0]                  port_out_valid,
    output logic [PORT_COUNT-1:0]                  port_out_ready,
    output logic [PORT_COUNT*FINAL_FIFO_WIDTH-1:0] port_in_data,
    output logic [PORT_COUNT-1:0]                  port_in_valid,
    input  logic [PORT_COUNT-1:0]                  port_in_ready,
    output logic [FINAL_FIFO_WIDTH-1:0]            up_data,
    output logic                                   up_valid,
    input  logic                                   up_ready,
    input  logic [FINAL_FIFO_WIDTH-1:0]            down_data,
    input  logic                                   down_valid,
    output logic                                   down_ready,
    output logic [DROP_CNT_WIDTH-1:0]              drop_count,
    output logic                                   has_flying_messages
);
    localparam int FFW = FINAL_FIFO_WIDTH;
    localparam int PW  = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;
    // Scan index carries one extra bit so rr_ptr + k never overflows before the wrap.
    localparam logic [PW:0]   PC_W = (PW+1)'(PORT_COUNT);
    localparam logic [PW-1:0] LAST = PW'(PORT_COUNT - 1);

    logic [PW-1:0]           rr_ptr;
    logic [PW-1:0]           gnt_idx;
    logic [PW:0]             scan_idx;
    logic                    gnt_found;
    logic [FFW-1:0]          gnt_word;
    logic                    up_load;
    logic                    pop_en;

    logic [FFW-1:0]          buf_data;
    logic                    buf_valid;
    logic                    buf_leaving;
    logic [HEADER_WIDTH-1:0] dest;
    logic                    dest_ok;
    logic                    push_en;

    // Up register can take a new word when empty or draining this cycle.
    assign up_load = !up_valid || up_ready;
    assign pop_en  = up_load && gnt_found && !reset;

    // First valid port at or after rr_ptr, wrapping explicitly for non-power-of-2 counts.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < PORT_COUNT; k++) begin
            scan_idx = {1'b0, rr_ptr} + (PW+1)'(k);
            if (scan_idx >= PC_W) scan_idx = scan_idx - PC_W;
            if (!gnt_found && port_out_valid[scan_idx[PW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx[PW-1:0];
            end
        end
    end

    // Select the granted unit's word.
    always_comb begin
        gnt_word = '0;
        for (int i = 0; i < PORT_COUNT; i++)
            if (gnt_idx == PW'(i)) gnt_word = port_out_data[i*FFW +: FFW];
    end

    assign dest    = buf_data[FFW-1 -: HEADER_WIDTH];
    assign dest_ok = int'({1'b0, dest}) < PORT_COUNT;
    assign push_en = buf_valid && dest_ok && !reset;

    for (genvar g = 0; g < PORT_COUNT; g++) begin : g_lane
        message_hub_router_lane #(.PW(PW), .HW(HEADER_WIDTH), .IDX(g)) u_lane (
            .pop_en  (pop_en),
            .gnt_idx (gnt_idx),
            .push_en (push_en),
            .dest    (dest),
            .pop     (port_out_ready[g]),
            .push    (port_in_valid[g])
        );
    end

    // A bad-header word leaves unconditionally; a good one waits for its target.
    assign buf_leaving  = buf_valid && (!dest_ok || |(port_in_valid & port_in_ready));
    // Nothing is accepted during reset since it would be discarded anyway.
    assign down_ready   = !reset && (!buf_valid || buf_leaving);
    assign port_in_data = {PORT_COUNT{buf_data}};

    assign has_flying_messages = |port_out_valid || up_valid || buf_valid || down_valid;

    // Upstream register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            up_valid <= 1'b0;
            up_data  <= '0;
            rr_ptr   <= '0;
        end else if (up_load) begin
            if (gnt_found) begin
                up_data  <= gnt_word;
                up_valid <= 1'b1;
                rr_ptr   <= (gnt_idx == LAST) ? '0 : gnt_idx + PW'(1);
            end else begin
                up_valid <= 1'b0;
            end
        end
    end

    // Downstream one-entry buffer; refill takes priority over the leaving word.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
        end else if (down_valid && down_ready) begin
            buf_valid <= 1'b1;
            buf_data  <= down_data;
        end else if (buf_leaving) begin
            buf_valid <= 1'b0;
        end
    end

    // Saturating count of words dropped for an out-of-range header.
    always_ff @(posedge clk) begin
        if (reset)
            drop_count <= '0;
        else if (buf_valid && !dest_ok && drop_count != '1)
            drop_count <= drop_count + DROP_CNT_WIDTH'(1);
    end
endmodule

// File: tb/tb_message_hub_router.sv
// Directed bench for message_hub_router: a 4-port build (a_*) and a 3-port
// build with a 2-bit drop counter (b_*) that share clock and reset.
module tb_message_hub_router;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [127:0] a_out_data;
    logic [3:0]   a_out_valid, a_out_ready, a_in_valid, a_in_ready;
    logic [127:0] a_in_data;
    logic [31:0]  a_up_data, a_down_data;
    logic         a_up_valid, a_up_ready, a_down_valid, a_down_ready, a_fly;
    logic [15:0]  a_drop;

    logic [95:0]  b_out_data, b_in_data;
    logic [2:0]   b_out_valid, b_out_ready, b_in_valid, b_in_ready;
    logic [31:0]  b_up_data, b_down_data;
    logic         b_up_valid, b_up_ready, b_down_valid, b_down_ready, b_fly;
    logic [1:0]   b_drop;

    int asserts = 0;
    int fails   = 0;

    message_hub_router dut_a (
        .clk(clk), .reset(reset),
        .port_out_data(a_out_data), .port_out_valid(a_out_valid), .port_out_ready(a_out_ready),
        .port_in_data(a_in_data), .port_in_valid(a_in_valid), .port_in_ready(a_in_ready),
        .up_data(a_up_data), .up_valid(a_up_valid), .up_ready(a_up_ready),
        .down_data(a_down_data), .down_valid(a_down_valid), .down_ready(a_down_ready),
        .drop_count(a_drop), .has_flying_messages(a_fly)
    );

    message_hub_router #(.PORT_COUNT(3), .DROP_CNT_WIDTH(2)) dut_b (
        .clk(clk), .reset(reset),
        .port_out_data(b_out_data), .port_out_valid(b_out_valid), .port_out_ready(b_out_ready),
        .port_in_data(b_in_data), .port_in_valid(b_in_valid), .port_in_ready(b_in_ready),
        .up_data(b_up_data), .up_valid(b_up_valid), .up_ready(b_up_ready),
        .down_data(b_down_data), .down_valid(b_down_valid), .down_ready(b_down_ready),
        .drop_count(b_drop), .has_flying_messages(b_fly)
    );

    task automatic test_reset();
        a_out_data = '0; a_out_valid = '0; a_in_ready = 4'hF; a_up_ready = 1'b1;
        a_down_data = '0; a_down_valid = 1'b0;
        b_out_data = '0; b_out_valid = '0; b_in_ready = 3'h7; b_up_ready = 1'b1;
        b_down_data = '0; b_down_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0; #1;
        asserts++; if (a_up_valid !== 1'b0 || a_up_data !== 32'h0) begin fails++;
            $display("FAIL reset_up: valid=%b data=%h, want 0/0", a_up_valid, a_up_data); end
        asserts++; if (a_out_ready !== 4'h0 || a_in_valid !== 4'h0) begin fails++;
            $display("FAIL reset_strobes: out_ready=%b in_valid=%b, want 0/0", a_out_ready, a_in_valid); end
        asserts++; if (a_down_ready !== 1'b1 || a_drop !== 16'h0 || a_fly !== 1'b0) begin fails++;
            $display("FAIL reset_down: down_ready=%b drop=%0d fly=%b, want 1/0/0", a_down_ready, a_drop, a_fly); end
        asserts++; if (b_up_valid !== 1'b0 || b_drop !== 2'h0 || b_down_ready !== 1'b1) begin fails++;
            $display("FAIL reset_b: up_valid=%b drop=%0d down_ready=%b, want 0/0/1", b_up_valid, b_drop, b_down_ready); end
    endtask

    task automatic test_round_robin();
        @(negedge clk);
        for (int i = 0; i < 4; i++) a_out_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
        a_out_valid = 4'hF; a_up_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            asserts++; if (a_out_ready !== (4'b0001 << (c % 4))) begin fails++;
                $display("FAIL rr_pop c=%0d: out_ready=%b, want %b", c, a_out_ready, 4'b0001 << (c % 4)); end
            if (c == 0) begin
                asserts++; if (a_up_valid !== 1'b0) begin fails++;
                    $display("FAIL rr_latency: up_valid=%b, want 0", a_up_valid); end
            end else begin
                asserts++; if (a_up_valid !== 1'b1 || a_up_data !== 32'hA000_0000 + 32'((c - 1) % 4)) begin fails++;
                    $display("FAIL rr_data c=%0d: valid=%b data=%h, want 1/%h", c, a_up_valid, a_up_data,
                             32'hA000_0000 + 32'((c - 1) % 4)); end
                asserts++; if (a_fly !== 1'b1) begin fails++;
                    $display("FAIL rr_fly: fly=%b, want 1", a_fly); end
            end
        end
        @(negedge clk); a_out_valid = 4'h0; #1;
        asserts++; if (a_out_ready !== 4'h0 || a_up_data !== 32'hA000_0003) begin fails++;
            $display("FAIL rr_tail: out_ready=%b data=%h, want 0/a0000003", a_out_ready, a_up_data); end
        @(negedge clk); #1;
        asserts++; if (a_up_valid !== 1'b0) begin fails++;
            $display("FAIL rr_drain: up_valid=%b, want 0", a_up_valid); end
    endtask

    task automatic test_up_stall();
        @(negedge clk);
        a_out_data[64 +: 32] = 32'hB000_0002; a_out_valid = 4'b0100; a_up_ready = 1'b0; #1;
        asserts++; if (a_out_ready !== 4'b0100) begin fails++;
            $display("FAIL stall_first_pop: out_ready=%b, want 0100", a_out_ready); end
        for (int s = 1; s <= 3; s++) begin
            @(negedge clk);
            if (s == 1) a_out_data[64 +: 32] = 32'hB000_0022;
            #1;
            asserts++; if (a_out_ready !== 4'h0 || a_up_valid !== 1'b1 || a_up_data !== 32'hB000_0002) begin fails++;
                $display("FAIL stall_hold s=%0d: out_ready=%b valid=%b data=%h, want 0/1/b0000002",
                         s, a_out_ready, a_up_valid, a_up_data); end
        end
        @(negedge clk); a_up_ready = 1'b1; #1;
        asserts++; if (a_out_ready !== 4'b0100 || a_up_data !== 32'hB000_0002) begin fails++;
            $display("FAIL stall_resume: out_ready=%b data=%h, want 0100/b0000002", a_out_ready, a_up_data); end
        @(negedge clk); #1;
        asserts++; if (a_up_data !== 32'hB000_0022 || a_out_ready !== 4'b0100) begin fails++;
            $display("FAIL stall_next: data=%h out_ready=%b, want b0000022/0100", a_up_data, a_out_ready); end
        @(negedge clk); a_out_valid = 4'h0;
        @(negedge clk);
    endtask

    task automatic test_down_stall();
        @(negedge clk);
        a_down_data = 32'h1234_5678; a_down_valid = 1'b1; a_in_ready = 4'b1101; #1;
        asserts++; if (a_down_ready !== 1'b1) begin fails++;
            $display("FAIL dn_accept: down_ready=%b, want 1", a_down_ready); end
        for (int s = 1; s <= 4; s++) begin
            @(negedge clk); a_down_valid = 1'b0; #1;
            asserts++; if (a_in_valid !== 4'b0010 || a_down_ready !== 1'b0 || a_in_data[32 +: 32] !== 32'h1234_5678) begin fails++;
                $display("FAIL dn_hold s=%0d: in_valid=%b down_ready=%b data=%h, want 0010/0/12345678",
                         s, a_in_valid, a_down_ready, a_in_data[32 +: 32]); end
        end
        @(negedge clk); a_in_ready = 4'hF; a_down_data = 32'h3000_00AA; a_down_valid = 1'b1; #1;
        asserts++; if (a_in_valid !== 4'b0010 || a_down_ready !== 1'b1) begin fails++;
            $display("FAIL dn_release: in_valid=%b down_ready=%b, want 0010/1", a_in_valid, a_down_ready); end
        @(negedge clk); a_down_valid = 1'b0; #1;
        asserts++; if (a_in_valid !== 4'b1000 || a_in_data[96 +: 32] !== 32'h3000_00AA) begin fails++;
            $display("FAIL dn_b2b: in_valid=%b data=%h, want 1000/300000aa", a_in_valid, a_in_data[96 +: 32]); end
        @(negedge clk); #1;
        asserts++; if (a_in_valid !== 4'h0) begin fails++;
            $display("FAIL dn_empty: in_valid=%b, want 0", a_in_valid); end
    endtask

    task automatic test_drop();
        @(negedge clk); a_down_data = 32'h7000_0001; a_down_valid = 1'b1;
        @(negedge clk); a_down_valid = 1'b0; #1;
        asserts++; if (a_in_valid !== 4'h0 || a_down_ready !== 1'b1 || a_drop !== 16'd0) begin fails++;
            $display("FAIL drop_cycle: in_valid=%b down_ready=%b drop=%0d, want 0/1/0", a_in_valid, a_down_ready, a_drop); end
        @(negedge clk); #1;
        asserts++; if (a_drop !== 16'd1 || a_fly !== 1'b0) begin fails++;
            $display("FAIL drop_count: drop=%0d fly=%b, want 1/0", a_drop, a_fly); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a_out_data[0 +: 32] = 32'hD000_0000; a_out_valid = 4'b0001; a_up_ready = 1'b0;
        a_down_data = 32'h2000_0005; a_down_valid = 1'b1; a_in_ready = 4'h0;
        @(negedge clk); a_down_valid = 1'b0; #1;
        asserts++; if (a_up_valid !== 1'b1 || a_in_valid !== 4'b0100 || a_drop !== 16'd1) begin fails++;
            $display("FAIL rst_fill: up_valid=%b in_valid=%b drop=%0d, want 1/0100/1", a_up_valid, a_in_valid, a_drop); end
        @(negedge clk); reset = 1'b1; a_up_ready = 1'b1; a_in_ready = 4'hF; #1;
        asserts++; if (a_out_ready !== 4'h0 || a_in_valid !== 4'h0) begin fails++;
            $display("FAIL rst_cycle: out_ready=%b in_valid=%b, want 0/0", a_out_ready, a_in_valid); end
        @(negedge clk);
        reset = 1'b0; a_out_data[32 +: 32] = 32'hD000_0001; a_out_valid = 4'b0011; #1;
        asserts++; if (a_up_valid !== 1'b0 || a_up_data !== 32'h0 || a_in_valid !== 4'h0 || a_drop !== 16'd0) begin fails++;
            $display("FAIL rst_state: up_valid=%b data=%h in_valid=%b drop=%0d, want 0/0/0/0",
                     a_up_valid, a_up_data, a_in_valid, a_drop); end
        asserts++; if (a_out_ready !== 4'b0001 || a_down_ready !== 1'b1) begin fails++;
            $display("FAIL rst_rrptr: out_ready=%b down_ready=%b, want 0001/1", a_out_ready, a_down_ready); end
        @(negedge clk); #1;
        asserts++; if (a_up_data !== 32'hD000_0000) begin fails++;
            $display("FAIL rst_first_word: data=%h, want d0000000", a_up_data); end
        @(negedge clk); a_out_valid = 4'h0;
        @(negedge clk);
    endtask

    task automatic test_three_ports();
        @(negedge clk);
        for (int i = 0; i < 3; i++) b_out_data[i*32 +: 32] = 32'hC000_0000 + 32'(i);
        b_out_valid = 3'h7; b_up_ready = 1'b1;
        b_down_data = 32'h2000_00BB; b_down_valid = 1'b1; b_in_ready = 3'h7;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) b_down_valid = 1'b0;
            #1;
            asserts++; if (b_out_ready !== (3'b001 << (c % 3))) begin fails++;
                $display("FAIL p3_pop c=%0d: out_ready=%b, want %b", c, b_out_ready, 3'b001 << (c % 3)); end
            if (c > 0) begin
                asserts++; if (b_up_data !== 32'hC000_0000 + 32'((c - 1) % 3)) begin fails++;
                    $display("FAIL p3_data c=%0d: data=%h, want %h", c, b_up_data, 32'hC000_0000 + 32'((c - 1) % 3)); end
            end
            if (c == 1) begin
                asserts++; if (b_in_valid !== 3'b100 || b_in_data[64 +: 32] !== 32'h2000_00BB) begin fails++;
                    $display("FAIL p3_down: in_valid=%b data=%h, want 100/200000bb", b_in_valid, b_in_data[64 +: 32]); end
            end
            if (c == 2) begin
                asserts++; if (b_in_valid !== 3'b000) begin fails++;
                    $display("FAIL p3_down_done: in_valid=%b, want 000", b_in_valid); end
            end
        end
        @(negedge clk); b_out_valid = 3'h0;
        @(negedge clk);
    endtask

    task automatic test_drop_saturate();
        b_down_data = 32'h3000_0001;
        for (int n = 0; n < 8; n++) begin
            int e;
            @(negedge clk); b_down_valid = (n < 5); #1;
            e = (n == 0) ? 0 : ((n - 1 > 3) ? 3 : n - 1);
            asserts++; if (b_drop !== 2'(e)) begin fails++;
                $display("FAIL sat n=%0d: drop=%0d, want %0d", n, b_drop, e); end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_up_stall();
        test_down_stall();
        test_drop();
        test_reset_mid();
        test_three_ports();
        test_drop_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, want finish before 200000");
        $fatal(1);
    end
endmodule
